// File: rtl/alu_exec_unit.sv
// ALU execution unit: takes one op from the reservation station, computes it
// (single-cycle ops or a multi-cycle multiply) and holds the result on the CDB until granted.
module alu_exec_unit #(
    parameter int DATA_W  = 3,
    parameter int ROB_W   = 2,
    parameter int MUL_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [2:0]        issue_opcode,
    input  logic [DATA_W-1:0] issue_val1,
    input  logic [DATA_W-1:0] issue_val2,
    input  logic [ROB_W-1:0]  issue_rob_idx,
    output logic              alu_busy,
    output logic              cdb_req,
    input  logic              cdb_grant,
    output logic              cdb_en,
    output logic [ROB_W-1:0]  cdb_rob_idx,
    output logic [DATA_W-1:0] cdb_val,
    output logic [7:0]        ops_done
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd5;
    localparam logic [2:0] OP_SRL = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    localparam logic [2:0] CNT_INIT  = 3'(MUL_LAT - 1);
    localparam bit         MUL_MULTI = (MUL_LAT > 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [2:0]          cnt_r;
    logic [DATA_W-1:0]   op_a_r;
    logic [DATA_W-1:0]   op_b_r;
    logic [DATA_W-1:0]   cdb_val_r;
    logic [ROB_W-1:0]    cdb_rob_idx_r;
    logic [7:0]          ops_done_r;
    logic                accept_s;
    logic                is_long_mul_s;

    function automatic logic [DATA_W-1:0] alu_compute(
        input logic [2:0]        op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W-1:0] res;
        res = '0;
        case (op)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_SLL:  res = (32'(b) >= DATA_W) ? '0 : (a << b);
            OP_SRL:  res = (32'(b) >= DATA_W) ? '0 : (a >> b);
            OP_MUL:  res = a * b;
            default: res = '0;
        endcase
        return res;
    endfunction

    // busy/req come only from registered state so rs_ready never loops back through us
    assign alu_busy      = (state_r != ST_IDLE);
    assign cdb_req       = (state_r == ST_WAIT);
    assign cdb_en        = cdb_req & cdb_grant;
    assign cdb_val       = cdb_val_r;
    assign cdb_rob_idx   = cdb_rob_idx_r;
    assign ops_done      = ops_done_r;
    assign accept_s      = issue_valid && (state_r == ST_IDLE);
    assign is_long_mul_s = (issue_opcode == OP_MUL) && MUL_MULTI;

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = is_long_mul_s ? ST_EXEC : ST_WAIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (cnt_r == 3'd1) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_EXEC;
                end
            end
            ST_WAIT: begin
                if (cdb_grant) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand latch, latency counter, held result and completion counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r         <= 3'd0;
            op_a_r        <= '0;
            op_b_r        <= '0;
            cdb_val_r     <= '0;
            cdb_rob_idx_r <= '0;
            ops_done_r    <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        cdb_rob_idx_r <= issue_rob_idx;
                        if (is_long_mul_s) begin
                            op_a_r <= issue_val1;
                            op_b_r <= issue_val2;
                            cnt_r  <= CNT_INIT;
                        end else begin
                            cdb_val_r <= alu_compute(issue_opcode, issue_val1, issue_val2);
                        end
                    end
                end
                ST_EXEC: begin
                    if (cnt_r == 3'd1) begin
                        cdb_val_r <= alu_compute(OP_MUL, op_a_r, op_b_r);
                        cnt_r     <= 3'd0;
                    end else begin
                        cnt_r <= cnt_r - 3'd1;
                    end
                end
                ST_WAIT: begin
                    if (cdb_grant) begin
                        ops_done_r <= ops_done_r + 8'd1;
                    end
                end
                default: begin
                    cnt_r <= 3'd0;
                end
            endcase
        end
    end

endmodule
